// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO between fetch and decode with
// valid/ready handshakes on both sides and a synchronous flush for redirects.
module if_id_queue #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       INST_W      = 32,
  parameter int unsigned       DEPTH       = 4,
  parameter logic [INST_W-1:0] BUBBLE_INST = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic [INST_W-1:0]        inst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     flush_i,
  output logic [ADDR_W-1:0]        pc_o,
  output logic [INST_W-1:0]        inst_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned    PW       = $clog2(DEPTH);
  localparam int unsigned    CW       = PW + 1;
  localparam int unsigned    EW       = ADDR_W + INST_W;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  assign w_full  = (r_cnt == FULL_CNT);
  assign w_empty = (r_cnt == '0);
  // ready_o deliberately ignores ready_i: a full queue never accepts, even on a pop.
  assign w_push  = valid_i & ~w_full;
  assign w_pop   = ~w_empty & ready_i;
  assign w_head  = r_mem[r_rd_ptr];

  assign ready_o = ~w_full;
  assign valid_o = ~w_empty;
  assign count_o = r_cnt;

  always_comb begin
    pc_o   = '0;
    inst_o = BUBBLE_INST;
    if (!w_empty) begin
      pc_o   = w_head[EW-1:INST_W];
      inst_o = w_head[INST_W-1:0];
    end
  end

  // Storage needs no reset; entries are only visible once counted by r_cnt.
  always_ff @(posedge clk) begin
    if (w_push && !flush_i) begin
      r_mem[r_wr_ptr] <= {pc_i, inst_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] BUBBLE = 32'h00000013;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc_i;
  logic [INST_W-1:0] inst_i;
  logic              valid_i;
  logic              ready_o;
  logic              flush_i;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] inst_o;
  logic              valid_o;
  logic              ready_i;
  logic [2:0]        count_o;

  int unsigned n_checks;
  int unsigned n_errors;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t model_q[$];

  if_id_queue #(
    .ADDR_W     (ADDR_W),
    .INST_W     (INST_W),
    .DEPTH      (DEPTH),
    .BUBBLE_INST(BUBBLE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pc_i   (pc_i),
    .inst_i (inst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .flush_i(flush_i),
    .pc_o   (pc_o),
    .inst_o (inst_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .count_o(count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every output against the reference model's view of the queue.
  task automatic check_outputs(input string tag);
    int unsigned sz;
    sz = model_q.size();
    check({tag, ".valid_o"}, 64'(valid_o), 64'(sz != 0));
    check({tag, ".ready_o"}, 64'(ready_o), 64'(sz < DEPTH));
    check({tag, ".count_o"}, 64'(count_o), 64'(sz));
    check({tag, ".pc_o"},    64'(pc_o),    (sz == 0) ? 64'd0 : 64'(model_q[0].pc));
    check({tag, ".inst_o"},  64'(inst_o),  (sz == 0) ? 64'(BUBBLE) : 64'(model_q[0].inst));
  endtask

  // Drive one cycle of inputs, advance the model for the coming edge, then
  // check outputs just after that edge.
  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic rdy, input logic fl);
    entry_t e;
    bit     do_push;
    bit     do_pop;
    valid_i = v;
    pc_i    = pc;
    inst_i  = inst;
    ready_i = rdy;
    flush_i = fl;
    if (fl) begin
      model_q.delete();
    end else begin
      do_push = v && (model_q.size() < DEPTH);
      do_pop  = rdy && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.pc   = pc;
        e.inst = inst;
        model_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] next_pc;
    n_checks = 0;
    n_errors = 0;
    rst     = 1'b1;
    valid_i = 1'b0;
    pc_i    = '0;
    inst_i  = '0;
    ready_i = 1'b0;
    flush_i = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.inst_const", 64'(inst_o), 64'h13);
    rst = 1'b0;

    // Single pass
    step("single_push", 1'b1, 32'h80000000, 32'h00500093, 1'b0, 1'b0);
    check("single.pc_const", 64'(pc_o), 64'h80000000);
    check("single.inst_const", 64'(inst_o), 64'h00500093);
    step("single_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("single.empty_const", 64'(valid_o), 64'd0);

    // Fill and backpressure
    for (int i = 0; i < 4; i++) begin
      step("fill", 1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 1'b0);
    end
    check("fill.count_const", 64'(count_o), 64'd4);
    check("fill.ready_const", 64'(ready_o), 64'd0);
    step("fifth_push", 1'b1, 32'h110, 32'hA004, 1'b0, 1'b0);
    // Full queue rejects even while popping
    step("full_push_pop", 1'b1, 32'h114, 32'hA005, 1'b1, 1'b0);
    check("fullpop.head_const", 64'(pc_o), 64'h104);
    for (int i = 0; i < 4; i++) begin
      step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check("drain.empty_const", 64'(valid_o), 64'd0);

    // Wrap-around with concurrent push/pop at occupancy 2
    next_pc = 32'h1000;
    for (int i = 0; i < 2; i++) begin
      step("wrap_prefill", 1'b1, next_pc, next_pc ^ 32'h5A5A, 1'b0, 1'b0);
      next_pc += 4;
    end
    for (int i = 0; i < 10; i++) begin
      step("wrap", 1'b1, next_pc, next_pc ^ 32'h5A5A, 1'b1, 1'b0);
      next_pc += 4;
      check("wrap.count_const", 64'(count_o), 64'd2);
    end
    check("wrap.head_const", 64'(pc_o), 64'h1000 + 64'(4 * 10));

    // Flush priority over push and pop
    step("pre_flush", 1'b1, next_pc, 32'h1, 1'b0, 1'b0);
    check("preflush.count_const", 64'(count_o), 64'd3);
    step("flush", 1'b1, 32'h200, 32'h2, 1'b1, 1'b1);
    check("flush.count_const", 64'(count_o), 64'd0);
    step("post_flush_push", 1'b1, 32'h300, 32'h3, 1'b0, 1'b0);
    check("postflush.pc_const", 64'(pc_o), 64'h300);
    step("post_flush_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Async reset mid-stream
    step("ar_fill0", 1'b1, 32'h3300, 32'h7, 1'b0, 1'b0);
    step("ar_fill1", 1'b1, 32'h3304, 32'h8, 1'b0, 1'b0);
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_q.delete();
    check("async_rst.valid", 64'(valid_o), 64'd0);
    check("async_rst.count", 64'(count_o), 64'd0);
    check_outputs("async_rst");
    #1 rst = 1'b0;
    step("ar_push", 1'b1, 32'h400, 32'h9, 1'b0, 1'b0);
    check("ar.pc_const", 64'(pc_o), 64'h400);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(99) < 70),
           $urandom(),
           $urandom(),
           ($urandom_range(99) < 55),
           ($urandom_range(99) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry instruction queue between fetch and decode.
- Uses valid/ready handshakes on both sides instead of a global stall, so fetch can run ahead of decode by up to DEPTH instructions.
- Synchronous flush empties the queue on branch/jump/trap redirect.
- When the queue is empty, decode sees a bubble: valid low, zero PC, NOP instruction.

Parameters:
- ADDR_W, 32, PC width in bits.
- INST_W, 32, instruction width in bits.
- DEPTH, 4, number of queue entries; power of two, >= 2.
- BUBBLE_INST, 32'h00000013, instruction driven on inst_o when the queue is empty (RISC-V addi x0,x0,0).

Ports:
- clk  input  1  core clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- pc_i  input  ADDR_W  PC of the fetched instruction.
- inst_i  input  INST_W  fetched instruction.
- valid_i  input  1  fetch offers pc_i/inst_i this cycle.
- ready_o  output  1  queue accepts; equals !full.
- flush_i  input  1  from ctrl; discard all entries this cycle.
- pc_o  output  ADDR_W  head PC to decode.
- inst_o  output  INST_W  head instruction to decode.
- valid_o  output  1  head entry valid; equals !empty.
- ready_i  input  1  decode consumes head this cycle.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x (ADDR_W+INST_W) array; rd_ptr, wr_ptr of $clog2(DEPTH) bits with natural wrap DEPTH-1 -> 0; occupancy counter cnt.
- Reset (rst high, asynchronous): rd_ptr=0, wr_ptr=0, cnt=0. Outputs: valid_o=0, ready_o=1, count_o=0, pc_o=0, inst_o=BUBBLE_INST. Array contents are don't-care.
- push = valid_i & ready_o; pop = valid_o & ready_i.
- ready_o = (cnt != DEPTH). It does not depend on ready_i: there is no pass-through when full, so a full queue rejects a push even if a pop occurs in the same cycle.
- Output path: combinational from head entry. When cnt==0: pc_o=0, inst_o=BUBBLE_INST, valid_o=0.
- Latency: an entry pushed at edge N is visible on pc_o/inst_o after edge N (cycle N+1) at the earliest. There is no same-cycle input-to-output bypass.
- Per rising edge, with flush_i having highest priority:
  - flush_i=1: rd_ptr=0, wr_ptr=0, cnt=0. Any same-cycle push or pop is ignored, and the offered input is dropped.
  - push only: write at wr_ptr, wr_ptr+1, cnt+1.
  - pop only: rd_ptr+1, cnt-1.
  - push and pop: both pointers advance, cnt unchanged. Legal only when 0<cnt<DEPTH, given the rules above.
  - neither: hold all state.
- Order is strictly FIFO; no entry is ever duplicated or lost except by flush.
- Inputs while full, or ready_i while empty, have no effect. No error flag is raised.
- Reset asserted mid-operation: all state clears immediately, independent of clk. The first push after deassertion is accepted on the first rising edge with rst low.
- count_o = cnt, registered.

Test Plan:
- Reset then idle: assert rst for 2 cycles with valid_i=0 -> valid_o=0, ready_o=1, count_o=0, pc_o=0, inst_o=32'h00000013.
- Single pass: push pc=0x80000000 inst=0x00500093 with ready_i=0 -> next cycle valid_o=1, pc_o=0x80000000, inst_o=0x00500093, count_o=1. Then set ready_i=1 for one cycle -> valid_o=0, count_o=0.
- Fill and backpressure (DEPTH=4): push PCs 0x100, 0x104, 0x108, 0x10C with ready_i=0 -> count_o=4, ready_o=0. A fifth push of 0x110 is rejected. Drain with ready_i=1 -> heads appear in order 0x100, 0x104, 0x108, 0x10C, then valid_o=0.
- Wrap-around with concurrent push/pop: hold count_o=2 while pushing and popping every cycle for 10 cycles with PCs incrementing by 4 -> count_o stays 2, every PC is output exactly once in order, and pointers wrap past 3 correctly.
- Flush priority: with count_o=3, assert flush_i together with valid_i=1 (pc 0x200) and ready_i=1 -> next cycle count_o=0, valid_o=0. 0x200 never appears; a later push of 0x300 is output first.
- Async reset mid-stream: with count_o=2, assert rst between clock edges -> valid_o=0 and count_o=0 before the next edge. After release, push 0x400 -> output 0x400 the following cycle.
